count_sequence_checker: RTL
===========================

Name: count_sequence_checker

Overview:
Downstream consumer of the preloaded free-running counter (load_and_count `counter_value`). Samples the counter every enabled cycle and checks that it advances by STEP modulo 2^WIDTH. Reports lock status, a saturating error count, and per-error events over a valid/ready interface for a monitor or CSR block. Used on-chip and in simulation to qualify the counter stage.

Parameters:
WIDTH, 16, counter width; must match the upstream counter.
STEP, 1, expected increment per enabled cycle, applied modulo 2^WIDTH.
ERR_W, 8, width of the saturating error counter.
LOCK_COUNT, 2, consecutive matching samples needed to assert locked; must be >= 1.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
en  in  1  sampling enable.
clear  in  1  synchronous clear of error state.
counter_value  in  WIDTH  upstream counter output.
locked  out  1  sequence verified.
err_count  out  ERR_W  saturating mismatch count.
err_valid  out  1  error event pending.
err_ready  in  1  consumer accepts the event.
err_expected  out  WIDTH  expected value in the pending event.
err_actual  out  WIDTH  sampled value in the pending event.
overflow  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset: rst asserted clears all outputs to 0 immediately (asynchronous) and sets state to IDLE. Internal prev/expected registers and the streak counter are also cleared to 0.
- Priority: rst > clear > normal operation.
- States:
  - IDLE: en=0. Counters and event buffer are held.
  - ACQUIRE: the first enabled sample sets expected <= sample+STEP. No check is made.
  - TRACK: checking is active, streak < LOCK_COUNT.
  - LOCKED: checking is active, streak reached LOCK_COUNT.
- Transitions:
  - IDLE -> ACQUIRE when en=1. That cycle's sample is the acquisition sample.
  - en=0 from any state -> IDLE. locked drops on the next edge.
- Check, on each enabled cycle in TRACK or LOCKED:
  - match = (counter_value == expected).
  - expected <= counter_value + STEP in all cases, so the checker resyncs to the actual value.
  - Match: streak increments, saturating at LOCK_COUNT. streak==LOCK_COUNT -> LOCKED.
  - Mismatch: streak <= 0, state -> TRACK, and an error event is raised.
- locked is registered. It is 1 in LOCKED only.
- Timing from acquisition: locked rises at the edge after the LOCK_COUNT-th consecutive match, i.e. LOCK_COUNT+1 enabled edges after acquisition.
- Wrap: all arithmetic is modulo 2^WIDTH. FFFF followed by 0000 is a match for STEP=1.
- err_count: increments on each mismatch and saturates at 2^ERR_W-1. It never wraps.
- Event buffer (single entry):
  - On mismatch, load {expected, counter_value} and set err_valid on the next edge.
  - Contents are stable while err_valid=1 and err_ready=0.
  - A handshake (err_valid & err_ready) empties the buffer on that edge.
  - Mismatch while full and no handshake: the new event is dropped, the old event is kept, and overflow <= 1.
  - Mismatch in the same cycle as a handshake: the new event is loaded and err_valid stays 1. No overflow.
- clear: err_count <= 0, overflow <= 0, err_valid <= 0, streak <= 0, locked <= 0. State becomes ACQUIRE if en=1, else IDLE.
- Reset mid-operation: rst asserted at any time, including mid-handshake, drops everything immediately. Operation restarts from IDLE after deassertion.

Decomposition:
- Package count_check_pkg:
  - state enum {IDLE, ACQUIRE, TRACK, LOCKED}.
  - packed struct err_event_t {expected, actual} parameterised via a WIDTH localparam default 16.
  - Saturating-increment function.
- Sub-module count_err_event_buf:
  - Single-entry valid/ready holding buffer.
  - Inputs: push, data. Outputs: valid, data. Input: ready.
  - Asserts drop on push-while-full-without-pop; overflow latches from this signal.

Test Plan:
- Preload A5B6, en=1, +1 per cycle for 10 cycles -> locked=1 from the 3rd sample edge onward, err_count=0, err_valid never 1.
- Wrap: FFFD, FFFE, FFFF, 0000, 0001 -> no error, locked=1 by 0000 and held through 0001.
- Jump: A5B6..A5B8 then A5BA -> err_valid=1 next cycle with expected=A5B9, actual=A5BA, err_count=1, locked=0. Then A5BB, A5BC -> locked=1 again.
- Backpressure: err_ready=0, two mismatches (expect 0010 got 0012; expect 0013 got 0020) -> err_valid held with 0010/0012, overflow=1, err_count=2. err_ready=1 for one cycle -> err_valid=0. clear -> overflow=0, err_count=0.
- Saturation with ERR_W=2: 5 consecutive mismatches -> err_count=3 and stays 3.
- Async reset: assert rst mid-cycle while locked=1 and err_valid=1 -> all outputs 0 before the next clk edge. After release with en=1 -> ACQUIRE, and locked returns LOCK_COUNT+1 edges later.

Source files
------------

// File: rtl/count_check_pkg.sv
// Shared types and helpers for the counter sequence checker.
package count_check_pkg;

    // Width of the standalone event record; matches the default counter width.
    localparam int EVENT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } check_state_t;

    typedef struct packed {
        logic [EVENT_WIDTH-1:0] expected;
        logic [EVENT_WIDTH-1:0] actual;
    } err_event_t;

    // Increment that sticks at limit instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/count_err_event_buf.sv
// Single-entry valid/ready holding buffer for mismatch events.
module count_err_event_buf
    import count_check_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          drop
);

    logic pop;

    assign pop  = valid & ready;
    assign drop = push & valid & ~ready & ~flush;

    // Hold one event; a handshake frees the slot on the same edge a new event may land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push && (!valid || pop)) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/count_sequence_checker.sv
// Checks that an upstream counter advances by STEP every enabled cycle.
module count_sequence_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STEP       = 1,
    parameter int ERR_W      = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] counter_value,
    output logic             locked,
    output logic [ERR_W-1:0] err_count,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_actual,
    output logic             overflow
);

    localparam int               STREAK_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] STEP_MOD   = WIDTH'(STEP);
    localparam logic [31:0]      STREAK_MAX = 32'(LOCK_COUNT);
    localparam logic [31:0]      ERR_MAX    = (ERR_W >= 32) ? 32'hFFFF_FFFF
                                                            : ((32'd1 << ERR_W) - 32'd1);

    typedef struct packed {
        logic [WIDTH-1:0] expected;
        logic [WIDTH-1:0] actual;
    } event_t;

    check_state_t        state;
    check_state_t        next_state;
    logic [WIDTH-1:0]    expected;
    logic [WIDTH-1:0]    next_expected;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] next_streak;
    logic                mismatch;
    logic                drop;
    event_t              push_event;
    event_t              held_event;

    // Next-state logic: acquire on the first enabled sample, then compare and resync every cycle.
    always_comb begin
        next_state    = state;
        next_expected = expected;
        next_streak   = streak;
        mismatch      = 1'b0;
        if (clear) begin
            next_streak = '0;
            if (en) begin
                next_state    = ACQUIRE;
                next_expected = counter_value + STEP_MOD;
            end else begin
                next_state = IDLE;
            end
        end else if (!en) begin
            next_state = IDLE;
        end else if (state == IDLE) begin
            next_state    = ACQUIRE;
            next_expected = counter_value + STEP_MOD;
            next_streak   = '0;
        end else begin
            next_expected = counter_value + STEP_MOD;
            if (counter_value == expected) begin
                next_streak = STREAK_W'(sat_inc(32'(streak), STREAK_MAX));
                next_state  = (32'(next_streak) == STREAK_MAX) ? LOCKED : TRACK;
            end else begin
                next_streak = '0;
                next_state  = TRACK;
                mismatch    = 1'b1;
            end
        end
    end

    // Sequence tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            expected <= '0;
            streak   <= '0;
        end else begin
            state    <= next_state;
            expected <= next_expected;
            streak   <= next_streak;
        end
    end

    // Error statistics: saturating mismatch count and sticky dropped-event flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (mismatch) begin
                err_count <= ERR_W'(sat_inc(32'(err_count), ERR_MAX));
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign push_event = {expected, counter_value};

    count_err_event_buf #(
        .DW (2 * WIDTH)
    ) u_event_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .push      (mismatch),
        .load_data (push_event),
        .ready     (err_ready),
        .valid     (err_valid),
        .data      (held_event),
        .drop      (drop)
    );

    assign locked       = (state == LOCKED);
    assign err_expected = held_event.expected;
    assign err_actual   = held_event.actual;

endmodule
